// File: rtl/max_finder.sv
// Classification stage: captures one signed output per neuron, then scans the
// buffer serially (one entry per cycle) and reports the index/value of the maximum.
module max_finder #(
    parameter int NUM_INPUTS = 10,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_INPUTS-1:0]            i_valid,
    output logic [IDX_WIDTH-1:0]             o_index,
    output logic signed [DATA_WIDTH-1:0]     o_max,
    output logic                             o_valid,
    output logic                             o_busy
);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_SEARCH  = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_INPUTS - 1);

    logic [1:0]                   r_state;
    logic signed [DATA_WIDTH-1:0] r_buf [NUM_INPUTS];
    logic [NUM_INPUTS-1:0]        r_got;
    logic [IDX_WIDTH-1:0]         r_cnt;
    logic signed [DATA_WIDTH-1:0] r_best;
    logic [IDX_WIDTH-1:0]         r_best_idx;

    logic signed [DATA_WIDTH-1:0] w_entry;
    logic signed [DATA_WIDTH-1:0] w_best;
    logic [IDX_WIDTH-1:0]         w_best_idx;
    logic                         w_all;

    assign w_all  = &(r_got | i_valid);
    assign o_busy = (r_state == ST_SEARCH);

    // Running-maximum update for the entry under the scan pointer; strict '>' keeps the lowest index on ties.
    always_comb begin
        w_entry    = r_buf[r_cnt];
        w_best     = r_best;
        w_best_idx = r_best_idx;
        if (r_cnt == '0) begin
            w_best     = r_buf[0];
            w_best_idx = '0;
        end else if (w_entry > r_best) begin
            w_best     = w_entry;
            w_best_idx = r_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_COLLECT;
            r_got      <= '0;
            r_cnt      <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
                r_buf[k] <= '0;
            end
            o_index    <= '0;
            o_max      <= '0;
            o_valid    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (r_state)
                ST_COLLECT, ST_DONE: begin
                    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
                        if (i_valid[k]) begin
                            r_buf[k] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    r_got <= r_got | i_valid;
                    if (w_all) begin
                        r_state <= ST_SEARCH;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= ST_COLLECT;
                    end
                end
                ST_SEARCH: begin
                    r_best     <= w_best;
                    r_best_idx <= w_best_idx;
                    r_cnt      <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= ST_DONE;
                        o_index <= w_best_idx;
                        o_max   <= w_best;
                        o_valid <= 1'b1;
                        r_got   <= '0;
                    end
                end
                default: r_state <= ST_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_max_finder.sv
// Directed bench for max_finder: expected results are queued when a set is driven
// and popped by a monitor whenever o_valid pulses.
module tb_max_finder;

    localparam int N  = 10;
    localparam int DW = 16;
    localparam int IW = 4;

    logic              clk;
    logic              rst;
    logic [N*DW-1:0]   i_data;
    logic [N-1:0]      i_valid;
    logic [IW-1:0]     o_index;
    logic [DW-1:0]     o_max;
    logic              o_valid;
    logic              o_busy;

    max_finder #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_index (o_index),
        .o_max   (o_max),
        .o_valid (o_valid),
        .o_busy  (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic signed [DW-1:0] vals [N];
    logic [IW+DW-1:0] sb [$];
    logic prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference argmax over vals: first strictly-greater entry wins.
    task automatic push_expected();
        logic signed [DW-1:0] m;
        logic [IW-1:0] mi;
        m  = vals[0];
        mi = '0;
        for (int k = 1; k < N; k++) begin
            if (vals[k] > m) begin
                m  = vals[k];
                mi = IW'(k);
            end
        end
        sb.push_back({mi, m});
    endtask

    // Called just after an edge; drives mask for one edge, returns just after it.
    task automatic present(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) i_data[k*DW +: DW] = vals[k];
        i_valid = mask;
        @(posedge clk); #1;
        i_valid = '0;
    endtask

    // Called just after the capture edge E0; counts edges to o_valid and busy cycles.
    task automatic wait_result(output int lat, output int busy);
        lat  = -1;
        busy = 0;
        for (int e = 0; e < 40; e++) begin
            if (o_busy) busy++;
            if (o_valid) begin
                lat = e;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (o_valid) begin
            check("valid_consecutive", {31'b0, prev_valid}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_valid", {31'b0, o_valid}, 32'd0);
            end else begin
                logic [IW+DW-1:0] e;
                e = sb.pop_front();
                check("o_index", {28'b0, o_index}, {28'b0, e[IW+DW-1:DW]});
                check("o_max",   {16'b0, o_max},   {16'b0, e[DW-1:0]});
            end
        end
        prev_valid <= o_valid;
    end

    initial begin
        int lat, busy;
        rst     = 1'b0;
        i_valid = '0;
        i_data  = '0;
        #3;
        check("rst_o_index", {28'b0, o_index}, 32'd0);
        check("rst_o_max",   {16'b0, o_max},   32'd0);
        check("rst_o_valid", {31'b0, o_valid}, 32'd0);
        check("rst_o_busy",  {31'b0, o_busy},  32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Ascending values, all on one cycle
        for (int k = 0; k < N; k++) vals[k] = 16'(100 * k);
        push_expected();
        present('1);
        wait_result(lat, busy);
        check("asc_latency", lat, 32'd10);
        check("asc_busy",    busy, 32'd10);
        @(posedge clk); #1;

        // All negative, maximum -3 at index 1
        vals = '{-16'sd5, -16'sd3, -16'sd7, -16'sd9, -16'sd4,
                 -16'sd8, -16'sd6, -16'sd10, -16'sd11, -16'sd12};
        push_expected();
        present('1);
        wait_result(lat, busy);
        check("neg_latency", lat, 32'd10);
        check("neg_o_max_raw", {16'b0, o_max}, 32'h0000FFFD);
        @(posedge clk); #1;

        // Tie between indices 2 and 6
        for (int k = 0; k < N; k++) vals[k] = 16'(k * 16);
        vals[2] = 16'h0400;
        vals[6] = 16'h0400;
        push_expected();
        present('1);
        wait_result(lat, busy);
        check("tie_o_index", {28'b0, o_index}, 32'd2);
        @(posedge clk); #1;

        // Staggered: 0-4 on cycle 0, 5-9 on cycle 3
        for (int k = 0; k < N; k++) vals[k] = 16'(k * 3 - 20);
        vals[7] = 16'h7FFF;
        push_expected();
        present(10'h01F);
        check("stag_busy_c1", {31'b0, o_busy}, 32'd0);
        @(posedge clk); #1;
        check("stag_busy_c2", {31'b0, o_busy}, 32'd0);
        @(posedge clk); #1;
        check("stag_busy_c3", {31'b0, o_busy}, 32'd0);
        present(10'h3E0);
        wait_result(lat, busy);
        check("stag_latency", lat, 32'd10);
        check("stag_busy",    busy, 32'd10);

        // Drop during SEARCH, then back-to-back set in the DONE cycle
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) vals[k] = 16'(k);
        vals[4] = 16'sd50;
        push_expected();
        present('1);
        repeat (3) begin @(posedge clk); #1; end
        i_data[DW-1:0] = 16'h7FFF;
        i_valid = 10'h001;
        @(posedge clk); #1;
        i_valid = '0;
        wait_result(lat, busy);
        check("drop_latency", lat, 32'd6);
        for (int k = 0; k < N; k++) vals[k] = 16'(200 - k);
        vals[8] = 16'sd900;
        push_expected();
        present('1);
        check("b2b_busy_restart", {31'b0, o_busy}, 32'd1);
        wait_result(lat, busy);
        check("b2b_latency", lat, 32'd10);
        @(posedge clk); #1;

        // Reset in the middle of SEARCH at cnt=5
        for (int k = 0; k < N; k++) vals[k] = 16'(k + 1);
        present('1);
        repeat (5) begin @(posedge clk); #1; end
        check("pre_rst_busy", {31'b0, o_busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_o_index", {28'b0, o_index}, 32'd0);
        check("midrst_o_max",   {16'b0, o_max},   32'd0);
        check("midrst_o_busy",  {31'b0, o_busy},  32'd0);
        check("midrst_o_valid", {31'b0, o_valid}, 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        check("aborted_no_valid", {31'b0, o_valid}, 32'd0);

        // Fresh set after reset
        for (int k = 0; k < N; k++) vals[k] = 16'(30 - 2 * k);
        vals[5] = 16'sd77;
        push_expected();
        present('1);
        wait_result(lat, busy);
        check("post_rst_latency", lat, 32'd10);
        repeat (3) begin @(posedge clk); #1; end
        check("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
